pll_clk_manager: RTL and testbench
==================================

PLL_CLK_MANAGER -- requirements
Module: pll_clk_manager

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of clock-enable channels (1..4).
REQ-002 SHALL have parameter ACC_W, default 24, phase-accumulator width per channel (8..32).
REQ-003 SHALL have parameter STABLE_CYC, default 1024, consecutive locked cycles required before release (2..65535).
REQ-004 SHALL have parameter LOSS_W, default 8, lock-loss counter width.
REQ-005 SHALL have port clk  input  1  single clock, PLL output domain; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port lock  input  1  raw PLL lock, asynchronous to clk.
REQ-008 SHALL have port inc  input  N_CH*ACC_W  per-channel phase increment, channel i at bits [i*ACC_W +: ACC_W].
REQ-009 SHALL have port inc_load  input  1  one-cycle strobe capturing inc into shadow registers.
REQ-010 SHALL have port ch_en  input  N_CH  per-channel run enable.
REQ-011 SHALL have port clk_en  output  N_CH  per-channel one-cycle clock-enable pulses.
REQ-012 SHALL have port rst_out_n  output  1  downstream synchronous active-low reset.
REQ-013 SHALL have port locked  output  1  high while in RUN.
REQ-014 SHALL have port loss_cnt  output  LOSS_W  saturating count of lock losses seen in RUN.
REQ-015 SHALL have port clr_loss  input  1  clears loss_cnt.

Function
REQ-016 SHALL synchronise lock through a 2-flop synchroniser (lock_s); all FSM decisions use lock_s only.
REQ-017 SHALL implement FSM states WAIT_LOCK, STABLE, RUN, LOST.
REQ-018 WAIT_LOCK: lock_s=1 -> STABLE with stable counter cleared; else stay.
REQ-019 STABLE: counter increments each cycle; lock_s=0 -> WAIT_LOCK, counter cleared; counter = STABLE_CYC-1 with lock_s=1 -> RUN.
REQ-020 RUN: lock_s=0 -> LOST; else stay.
REQ-021 LOST: unconditional -> WAIT_LOCK next cycle.
REQ-022 rst_out_n and locked SHALL be registered, high exactly while state is RUN (asserted the cycle after RUN entry, low the cycle after RUN exit).
REQ-023 On each RUN->LOST transition loss_cnt SHALL increment, saturating at 2^LOSS_W-1; clr_loss has priority over a simultaneous increment (result 0).
REQ-024 Per channel i, in RUN with ch_en[i]=1: acc_i <= (acc_i + inc_sh_i) mod 2^ACC_W; clk_en[i] registered = carry-out of that addition.
REQ-025 Pulse rate SHALL equal f_clk*inc_sh_i/2^ACC_W exactly on average; inc_sh_i=0 yields no pulses; inc_sh_i >= 2^(ACC_W-1) still yields at most one pulse per cycle.
REQ-026 ch_en[i]=0 SHALL hold acc_i and force clk_en[i]=0; re-enable resumes from held phase.
REQ-027 inc_load=1 SHALL update all shadow registers at that edge; new increments apply from the following cycle; accumulators not cleared.
REQ-028 Outside RUN all accumulators SHALL be cleared to 0 and clk_en=0.

Reset
REQ-029 reset_n=0 at a clock edge SHALL force: state WAIT_LOCK, synchroniser and stable counter 0, accumulators 0, shadow increments 0, clk_en 0, rst_out_n 0, locked 0, loss_cnt 0.
REQ-030 Reset mid-RUN SHALL NOT increment loss_cnt; after release the full STABLE_CYC qualification repeats.

Verification (STABLE_CYC=16, ACC_W=8, N_CH=2)
REQ-031 lock held 1 from reset release -> rst_out_n and locked rise exactly 2 (sync) + 1 + 16 + 1 cycles after lock first sampled high; clk_en stays 0 before that.
REQ-032 lock drops for 1 cycle at STABLE count 10 -> return to WAIT_LOCK, full 16-cycle count restarts; loss_cnt stays 0.
REQ-033 inc ch0=64, ch1=3 loaded, both enabled, RUN -> ch0 pulses every 4th cycle; ch1 exactly 3 pulses per 256 cycles.
REQ-034 In RUN lock drops -> rst_out_n/locked low within 4 cycles, loss_cnt=1, accumulators 0; 300 loss events with LOSS_W=8 -> loss_cnt=255; clr_loss coincident with loss -> 0.
REQ-035 ch_en[0] low for 10 cycles mid-run, inc_load of 128 during gap -> no ch0 pulses in gap; afterward ch0 pulses every 2nd cycle, phase continuous from held value.

Source files
------------

// File: rtl/pll_clk_manager.sv
// PLL lock qualification with downstream reset release, plus per-channel phase-accumulator clock enables.
// Clock enables and lock-loss counting operate only while the PLL is qualified as locked.
module pll_clk_manager #(
   parameter int N_CH       = 2,
   parameter int ACC_W      = 24,
   parameter int STABLE_CYC = 1024,
   parameter int LOSS_W     = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   lock,
   input  logic [N_CH*ACC_W-1:0]  inc,
   input  logic                   inc_load,
   input  logic [N_CH-1:0]        ch_en,
   output logic [N_CH-1:0]        clk_en,
   output logic                   rst_out_n,
   output logic                   locked,
   output logic [LOSS_W-1:0]      loss_cnt,
   input  logic                   clr_loss
);

   typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN, LOST} state_t;

   localparam logic [15:0]       STABLE_LAST = 16'(STABLE_CYC - 1);
   localparam logic [LOSS_W-1:0] LOSS_MAX    = '1;

   state_t      state;
   logic        lock_m;
   logic        lock_s;
   logic [15:0] stable_cnt;

   // lock comes straight from the PLL analog block, so it is resynchronised before any use
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= lock;
         lock_s <= lock_m;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= WAIT_LOCK;
         stable_cnt <= '0;
         locked     <= 1'b0;
         rst_out_n  <= 1'b0;
         loss_cnt   <= '0;
      end else begin
         locked    <= (state == RUN);
         rst_out_n <= (state == RUN);

         if (clr_loss)
            loss_cnt <= '0;
         else if (state == RUN && !lock_s && loss_cnt != LOSS_MAX)
            loss_cnt <= loss_cnt + 1'b1;

         case (state)
            WAIT_LOCK: begin
               if (lock_s) begin
                  state      <= STABLE;
                  stable_cnt <= '0;
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  state      <= WAIT_LOCK;
                  stable_cnt <= '0;
               end else if (stable_cnt == STABLE_LAST) begin
                  state <= RUN;
               end else begin
                  stable_cnt <= stable_cnt + 16'd1;
               end
            end
            RUN: begin
               if (!lock_s)
                  state <= LOST;
            end
            default: begin
               state <= WAIT_LOCK;
            end
         endcase
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [ACC_W-1:0] acc;
      logic [ACC_W-1:0] inc_sh;
      logic [ACC_W:0]   sum;
      logic             ce;

      // carry out of the wrap-around add is the enable pulse
      assign sum       = {1'b0, acc} + {1'b0, inc_sh};
      assign clk_en[i] = ce;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            acc    <= '0;
            inc_sh <= '0;
            ce     <= 1'b0;
         end else begin
            if (inc_load)
               inc_sh <= inc[i*ACC_W +: ACC_W];
            if (state != RUN) begin
               acc <= '0;
               ce  <= 1'b0;
            end else if (ch_en[i]) begin
               acc <= sum[ACC_W-1:0];
               ce  <= sum[ACC_W];
            end else begin
               ce <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pll_clk_manager.sv
// Bench for pll_clk_manager: directed scenarios plus randomized traffic against a cycle-level reference.
module tb_pll_clk_manager;
   localparam int N_CH       = 2;
   localparam int ACC_W      = 8;
   localparam int STABLE_CYC = 16;
   localparam int LOSS_W     = 8;
   localparam int MOD        = 1 << ACC_W;
   localparam int LOSS_SAT   = (1 << LOSS_W) - 1;

   logic                  clk      = 1'b0;
   logic                  reset_n  = 1'b0;
   logic                  lock     = 1'b0;
   logic                  inc_load = 1'b0;
   logic                  clr_loss = 1'b0;
   logic [N_CH*ACC_W-1:0] inc      = '0;
   logic [N_CH-1:0]       ch_en    = '0;
   logic [N_CH-1:0]       clk_en;
   logic                  rst_out_n;
   logic                  locked;
   logic [LOSS_W-1:0]     loss_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pll_clk_manager #(
      .N_CH(N_CH), .ACC_W(ACC_W), .STABLE_CYC(STABLE_CYC), .LOSS_W(LOSS_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .lock(lock), .inc(inc), .inc_load(inc_load),
      .ch_en(ch_en), .clk_en(clk_en), .rst_out_n(rst_out_n), .locked(locked),
      .loss_cnt(loss_cnt), .clr_loss(clr_loss)
   );

   // Reference: lock is seen two samples late; qualification needs STABLE_CYC+1 consecutive
   // synchronised-high samples, and one sample is swallowed right after a loss.
   logic [1:0]      m_pipe;
   logic            m_run, m_hold, m_locked;
   int              m_streak, m_loss;
   int              m_acc [N_CH];
   int              m_inc [N_CH];
   logic [N_CH-1:0] m_ce;

   always @(posedge clk) begin : model
      logic ls;
      ls = m_pipe[1];
      if (!reset_n) begin
         m_pipe <= '0; m_run <= 0; m_hold <= 0; m_locked <= 0; m_streak <= 0; m_loss <= 0;
         m_ce <= '0;
         for (int i = 0; i < N_CH; i++) begin m_acc[i] <= 0; m_inc[i] <= 0; end
      end else begin
         m_pipe   <= {m_pipe[0], lock};
         m_locked <= m_run;
         if (m_run) begin
            if (!ls) begin m_run <= 0; m_hold <= 1; end
         end else if (m_hold) m_hold <= 0;
         else if (!ls) m_streak <= 0;
         else if (m_streak == STABLE_CYC) begin m_run <= 1; m_streak <= 0; end
         else m_streak <= m_streak + 1;
         if (clr_loss) m_loss <= 0;
         else if (m_run && !ls) m_loss <= (m_loss < LOSS_SAT) ? m_loss + 1 : LOSS_SAT;
         for (int i = 0; i < N_CH; i++) begin
            if (inc_load) m_inc[i] <= int'(inc[i*ACC_W +: ACC_W]);
            if (!m_run) begin m_acc[i] <= 0; m_ce[i] <= 0; end
            else if (ch_en[i]) begin
               m_acc[i] <= (m_acc[i] + m_inc[i]) % MOD;
               m_ce[i]  <= (m_acc[i] + m_inc[i]) >= MOD;
            end else m_ce[i] <= 0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go_run();
      reset_n = 0; lock = 1; clr_loss = 0; inc_load = 0;
      tick(2);
      reset_n = 1;
      tick(22);
   endtask

   task automatic test_reset();
      reset_n = 0; lock = 1'($urandom); ch_en = 2'($urandom); inc = 16'($urandom); inc_load = 1;
      tick(3);
      inc_load = 0;
      checks++; if (clk_en !== 2'b00) begin errors++; $display("FAIL reset_clk_en got %b want 00", clk_en); end
      checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL reset_rst_out_n got %b want 0", rst_out_n); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
      checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_loss_cnt got %0d want 0", loss_cnt); end
      checks++; if (dut.g_ch[0].inc_sh !== 8'd0 || dut.g_ch[1].inc_sh !== 8'd0) begin
         errors++; $display("FAIL reset_inc_sh got %0d/%0d want 0/0", dut.g_ch[0].inc_sh, dut.g_ch[1].inc_sh); end
   endtask

   task automatic test_lock_timing();
      int n; bit early;
      lock = 0; reset_n = 1; ch_en = 2'b11;
      inc = {8'd7, 8'd200}; inc_load = 1; tick(1); inc_load = 0;
      tick(3);
      lock = 1; n = 0; early = 0;
      while (locked !== 1'b1 && n < 100) begin
         tick(1); n++;
         if (locked !== 1'b1 && clk_en !== 2'b00) early = 1;
      end
      checks++; if (n != 20) begin errors++; $display("FAIL lock_rise_edges got %0d want 20", n); end
      checks++; if (rst_out_n !== 1'b1) begin errors++; $display("FAIL lock_rst_out_n got %b want 1", rst_out_n); end
      checks++; if (early) begin errors++; $display("FAIL lock_early_clk_en got 1 want 0"); end
   endtask

   task automatic test_glitch();
      int n;
      reset_n = 0; lock = 0; tick(2); reset_n = 1; tick(2);
      lock = 1; n = 0;
      while (locked !== 1'b1 && n < 100) begin
         tick(1); n++;
         if (n == 11) lock = 0;
         if (n == 12) lock = 1;
         checks++; if (locked !== m_locked) begin errors++; $display("FAIL glitch_locked cyc %0d got %b want %b", n, locked, m_locked); end
      end
      checks++; if (n != 32) begin errors++; $display("FAIL glitch_rise_edges got %0d want 32", n); end
      checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL glitch_loss_cnt got %0d want 0", loss_cnt); end
   endtask

   task automatic test_rates();
      int c0, c1, last0; bit bad;
      ch_en = 2'b11; inc = {8'd3, 8'd64}; inc_load = 1; tick(1); inc_load = 0;
      c0 = 0; c1 = 0; last0 = -1; bad = 0;
      for (int i = 0; i < 256; i++) begin
         tick(1);
         if (clk_en[0]) begin
            if (last0 >= 0 && i - last0 != 4) bad = 1;
            last0 = i; c0++;
         end
         if (clk_en[1]) c1++;
         checks++; if (clk_en !== m_ce) begin errors++; if (errors < 20) $display("FAIL rates_clk_en cyc %0d got %b want %b", i, clk_en, m_ce); end
      end
      checks++; if (c0 != 64) begin errors++; $display("FAIL rates_ch0_count got %0d want 64", c0); end
      checks++; if (c1 != 3) begin errors++; $display("FAIL rates_ch1_count got %0d want 3", c1); end
      checks++; if (bad) begin errors++; $display("FAIL rates_ch0_period got irregular want 4"); end
   endtask

   task automatic test_gap();
      int c0, first, held, want_first;
      ch_en = 2'b10; c0 = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin inc = {8'd3, 8'd128}; inc_load = 1; end
         tick(1);
         inc_load = 0;
         if (clk_en[0]) c0++;
      end
      checks++; if (c0 != 0) begin errors++; $display("FAIL gap_pulses got %0d want 0", c0); end
      checks++; if (int'(dut.g_ch[0].acc) !== m_acc[0]) begin errors++; $display("FAIL gap_held_acc got %0d want %0d", dut.g_ch[0].acc, m_acc[0]); end
      held = m_acc[0];
      want_first = (held >= 128) ? 0 : 1;
      ch_en = 2'b11; c0 = 0; first = -1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (clk_en[0]) begin c0++; if (first < 0) first = i; end
         checks++; if (clk_en[0] !== 1'(((i - want_first) % 2) == 0 && i >= want_first)) begin
            errors++; if (errors < 20) $display("FAIL gap_resume cyc %0d got %b want every 2nd from %0d", i, clk_en[0], want_first); end
      end
      checks++; if (c0 != 10) begin errors++; $display("FAIL gap_resume_count got %0d want 10", c0); end
      checks++; if (first != want_first) begin errors++; $display("FAIL gap_phase first %0d want %0d (held %0d)", first, want_first, held); end
   endtask

   task automatic test_loss();
      int n;
      go_run();
      ch_en = 2'b11; inc = {8'd3, 8'd64}; inc_load = 1; tick(1); inc_load = 0; tick(10);
      lock = 0; n = 0;
      while (locked !== 1'b0 && n < 10) begin tick(1); n++; end
      checks++; if (n < 1 || n > 4) begin errors++; $display("FAIL loss_drop_edges got %0d want 1..4", n); end
      checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL loss_rst_out_n got %b want 0", rst_out_n); end
      tick(1);
      checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_count_one got %0d want 1", loss_cnt); end
      checks++; if (dut.g_ch[0].acc !== 8'd0 || dut.g_ch[1].acc !== 8'd0 || clk_en !== 2'b00) begin
         errors++; $display("FAIL loss_acc_clear got %0d/%0d en %b want 0/0 en 00", dut.g_ch[0].acc, dut.g_ch[1].acc, clk_en); end
      for (int k = 0; k < 300; k++) begin
         lock = 1; tick(22);
         lock = 0; tick(4);
         checks++; if (int'(loss_cnt) !== m_loss) begin errors++; if (errors < 20) $display("FAIL loss_track iter %0d got %0d want %0d", k, loss_cnt, m_loss); end
      end
      checks++; if (loss_cnt !== 8'd255) begin errors++; $display("FAIL loss_saturate got %0d want 255", loss_cnt); end
      lock = 1; tick(22);
      lock = 0; tick(2);
      clr_loss = 1; tick(1); clr_loss = 0; tick(2);
      checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL loss_clr_priority got %0d want 0", loss_cnt); end
   endtask

   task automatic test_reset_mid_run();
      int n;
      go_run();
      reset_n = 0; tick(1); reset_n = 1;
      n = 0;
      while (locked !== 1'b1 && n < 100) begin tick(1); n++; end
      checks++; if (n != 20) begin errors++; $display("FAIL midrun_requal_edges got %0d want 20", n); end
      checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL midrun_loss_cnt got %0d want 0", loss_cnt); end
   endtask

   task automatic test_random();
      go_run();
      for (int i = 0; i < 800; i++) begin
         ch_en    = 2'($urandom);
         inc      = 16'($urandom);
         inc_load = ($urandom_range(0, 7) == 0);
         lock     = ($urandom_range(0, 47) != 0);
         clr_loss = ($urandom_range(0, 60) == 0);
         tick(1);
         checks++; if (clk_en !== m_ce || locked !== m_locked || rst_out_n !== m_locked || int'(loss_cnt) !== m_loss) begin
            errors++;
            if (errors < 20) $display("FAIL random cyc %0d got en %b lk %b rn %b loss %0d want en %b lk %b loss %0d",
                                      i, clk_en, locked, rst_out_n, loss_cnt, m_ce, m_locked, m_loss);
         end
         checks++; if (int'(dut.g_ch[0].acc) !== m_acc[0] || int'(dut.g_ch[1].acc) !== m_acc[1]) begin
            errors++;
            if (errors < 20) $display("FAIL random_acc cyc %0d got %0d/%0d want %0d/%0d",
                                      i, dut.g_ch[0].acc, dut.g_ch[1].acc, m_acc[0], m_acc[1]);
         end
      end
      inc_load = 0; clr_loss = 0;
   endtask

   initial begin
      test_reset();
      test_lock_timing();
      test_glitch();
      test_rates();
      test_gap();
      test_loss();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
